// File: rtl/qa_qlp_responder_pkg.sv
// Shared definitions for the QLP-side memory responder.
// Holds the CCI response type codes, the fixed Rx header field offsets and
// the helper that packs a response header from a type code and a request tag.
package qa_qlp_responder_pkg;

  localparam int RX_HDR_W    = 18;
  localparam int TAG_W       = 14;
  localparam int RX_TYPE_LSB = 14;
  localparam int RX_TYPE_MSB = 17;

  typedef enum logic [3:0] {
    RSP_WR = 4'h1,
    RSP_RD = 4'h4,
    RSP_IR = 4'h8
  } rsp_type_e;

  // Rx header layout: type code in [17:14], echoed request tag in [13:0].
  function automatic logic [RX_HDR_W-1:0] packRxHdr(input rsp_type_e typ,
                                                    input logic [TAG_W-1:0] tag);
    logic [RX_HDR_W-1:0] hdr;
    hdr = '0;
    hdr[RX_TYPE_MSB:RX_TYPE_LSB] = typ;
    hdr[TAG_W-1:0] = tag;
    return hdr;
  endfunction

endpackage

// File: rtl/qa_qlp_mem_responder_if.sv
// CCI request/response channel bundle between an AFU/shim and the QLP end.
// Ports (grouped as interface signals):
//   C0Tx*  read request in, C0TxAlmFull flow control out
//   C1Tx*  write/interrupt request in, C1TxAlmFull flow control out
//   C0Rx*  read response out (plus tied-off valids)
//   C1Rx*  write/interrupt ack out
// master: the requesting side (AFU/shim or testbench).
// slave:  the responding side (qa_qlp_mem_responder).
interface qa_qlp_mem_responder_if
  import qa_qlp_responder_pkg::*;
#(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = RX_HDR_W,
  parameter int CCI_TX_HDR_WIDTH = 61
);

  logic [CCI_TX_HDR_WIDTH-1:0] C0TxHdr;
  logic                        C0TxRdValid;
  logic                        C0TxAlmFull;

  logic [CCI_TX_HDR_WIDTH-1:0] C1TxHdr;
  logic [CCI_DATA_WIDTH-1:0]   C1TxData;
  logic                        C1TxWrValid;
  logic                        C1TxIrValid;
  logic                        C1TxAlmFull;

  logic [CCI_RX_HDR_WIDTH-1:0] C0RxHdr;
  logic [CCI_DATA_WIDTH-1:0]   C0RxData;
  logic                        C0RxRdValid;
  logic                        C0RxWrValid;
  logic                        C0RxCgValid;
  logic                        C0RxUgValid;
  logic                        C0RxIrValid;

  logic [CCI_RX_HDR_WIDTH-1:0] C1RxHdr;
  logic                        C1RxWrValid;
  logic                        C1RxIrValid;

  modport master (
    output C0TxHdr, C0TxRdValid, C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
    input  C0TxAlmFull, C1TxAlmFull,
    input  C0RxHdr, C0RxData, C0RxRdValid, C0RxWrValid, C0RxCgValid,
           C0RxUgValid, C0RxIrValid,
    input  C1RxHdr, C1RxWrValid, C1RxIrValid
  );

  modport slave (
    input  C0TxHdr, C0TxRdValid, C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
    output C0TxAlmFull, C1TxAlmFull,
    output C0RxHdr, C0RxData, C0RxRdValid, C0RxWrValid, C0RxCgValid,
           C0RxUgValid, C0RxIrValid,
    output C1RxHdr, C1RxWrValid, C1RxIrValid
  );

endinterface

// File: rtl/qa_qlp_req_fifo.sv
// Synchronous request FIFO with first-word-fall-through head and occupancy.
// Ports:
//   clk, reset      clock, async active-high reset (empties the FIFO)
//   push_i, data_i  write side; a push while full is dropped
//   pop_i, data_o   read side; data_o shows the head entry whenever non-empty
//   empty_o, full_o status flags derived from the registered count
//   count_o         registered occupancy, 0..2^DEPTH_LG2
module qa_qlp_req_fifo #(
  parameter int WIDTH     = 20,
  parameter int DEPTH_LG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [DEPTH_LG2:0]   count_o
);

  localparam int DEPTH = 2**DEPTH_LG2;
  localparam logic [DEPTH_LG2:0] FULL_COUNT = (DEPTH_LG2+1)'(DEPTH);

  logic [WIDTH-1:0]     store_q [DEPTH];
  logic [DEPTH_LG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LG2:0]   count_q, count_d;
  logic                 pushOk;
  logic                 popOk;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign data_o  = store_q[rdPtr_q];
  assign count_o = count_q;

  // Fullness is judged on the registered count, so a push into a full FIFO
  // is dropped even if a pop happens in the same cycle.
  always_comb begin
    pushOk  = push_i && !full_o;
    popOk   = pop_i && !empty_o;
    wrPtr_d = wrPtr_q + DEPTH_LG2'(pushOk);
    rdPtr_d = rdPtr_q + DEPTH_LG2'(popOk);
    count_d = count_q + (DEPTH_LG2+1)'(pushOk) - (DEPTH_LG2+1)'(popOk);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      store_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/qa_qlp_mem_responder.sv
// QLP-end responder: services CCI C0 reads and C1 writes against a small
// internal line memory and returns tagged responses with fixed latency.
// Ports:
//   clk, reset  sole clock, async active-high reset
//   resetb      active-low reset toward the AFU, deassert synchronised by 2 flops
//   overflow    sticky flag: a request arrived while its FIFO was full
//   bus         CCI channel bundle (slave side): C0Tx/C1Tx requests in,
//               almost-full out, C0Rx read data and C1Rx acks out
module qa_qlp_mem_responder
  import qa_qlp_responder_pkg::*;
#(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_TX_HDR_WIDTH = 61,
  parameter int CCI_TAG_WIDTH    = 14,
  parameter int MEM_LINES_LG2    = 6,
  parameter int FIFO_DEPTH_LG2   = 4,
  parameter int ALM_FULL_SLACK   = 8,
  parameter int READ_LATENCY     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   resetb,
  output logic                   overflow,
  qa_qlp_mem_responder_if.slave  bus
);

  localparam int TAG_LINE_W = CCI_TAG_WIDTH + MEM_LINES_LG2;
  localparam int WR_W       = TAG_LINE_W + CCI_DATA_WIDTH;
  localparam int LINES      = 2**MEM_LINES_LG2;
  localparam logic [FIFO_DEPTH_LG2:0] ALM_THRESH =
    (FIFO_DEPTH_LG2+1)'(2**FIFO_DEPTH_LG2 - ALM_FULL_SLACK);

  logic [TAG_LINE_W-1:0]     rdHead;
  logic                      rdEmpty, rdFull, rdPop;
  logic [FIFO_DEPTH_LG2:0]   rdCount;
  logic [CCI_TAG_WIDTH-1:0]  rdTag;
  logic [MEM_LINES_LG2-1:0]  rdLine;
  logic [CCI_DATA_WIDTH-1:0] rdMemData;

  logic [WR_W-1:0]           wrHead;
  logic                      wrEmpty, wrFull, wrPop;
  logic [FIFO_DEPTH_LG2:0]   wrCount;
  logic [CCI_TAG_WIDTH-1:0]  wrTag;
  logic [MEM_LINES_LG2-1:0]  wrLine;
  logic [CCI_DATA_WIDTH-1:0] wrData;

  logic [CCI_DATA_WIDTH-1:0] mem_q [LINES];

  logic                      pipeValid_q [READ_LATENCY];
  logic [CCI_TAG_WIDTH-1:0]  pipeTag_q   [READ_LATENCY];
  logic [CCI_DATA_WIDTH-1:0] pipeData_q  [READ_LATENCY];

  logic                        c0RxValid_q;
  logic [CCI_RX_HDR_WIDTH-1:0] c0RxHdr_q;
  logic [CCI_DATA_WIDTH-1:0]   c0RxData_q;

  logic                      c1PendValid_q, c1PendValid_d;
  rsp_type_e                 c1PendType_q, c1PendType_d;
  logic [CCI_TAG_WIDTH-1:0]  c1PendTag_q, c1PendTag_d;

  logic                        c1RxWrValid_q, c1RxIrValid_q;
  logic [CCI_RX_HDR_WIDTH-1:0] c1RxHdr_q;

  logic       overflow_q, overflow_d;
  logic [1:0] rstSync_q;

  // Address bits above the memory index alias onto the same lines.
  logic unusedHdrBits;
  assign unusedHdrBits = ^{bus.C0TxHdr[CCI_TX_HDR_WIDTH-1:TAG_LINE_W],
                           bus.C1TxHdr[CCI_TX_HDR_WIDTH-1:TAG_LINE_W]};

  qa_qlp_req_fifo #(
    .WIDTH     (TAG_LINE_W),
    .DEPTH_LG2 (FIFO_DEPTH_LG2)
  ) u_rd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.C0TxRdValid),
    .data_i  (bus.C0TxHdr[TAG_LINE_W-1:0]),
    .pop_i   (rdPop),
    .data_o  (rdHead),
    .empty_o (rdEmpty),
    .full_o  (rdFull),
    .count_o (rdCount)
  );

  qa_qlp_req_fifo #(
    .WIDTH     (WR_W),
    .DEPTH_LG2 (FIFO_DEPTH_LG2)
  ) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.C1TxWrValid),
    .data_i  ({bus.C1TxData, bus.C1TxHdr[TAG_LINE_W-1:0]}),
    .pop_i   (wrPop),
    .data_o  (wrHead),
    .empty_o (wrEmpty),
    .full_o  (wrFull),
    .count_o (wrCount)
  );

  assign rdTag     = rdHead[CCI_TAG_WIDTH-1:0];
  assign rdLine    = rdHead[TAG_LINE_W-1:CCI_TAG_WIDTH];
  assign wrTag     = wrHead[CCI_TAG_WIDTH-1:0];
  assign wrLine    = wrHead[TAG_LINE_W-1:CCI_TAG_WIDTH];
  assign wrData    = wrHead[WR_W-1:TAG_LINE_W];
  assign rdMemData = mem_q[rdLine];

  // The read pipeline never stalls, so reads drain every cycle. A write pop
  // yields to an interrupt arriving in the same cycle, since both acks would
  // otherwise land on C1Rx together.
  assign rdPop = !rdEmpty;
  assign wrPop = !wrEmpty && !bus.C1TxIrValid;

  // Memory read is combinational in the pop cycle and the write lands on the
  // closing edge, so a same-cycle read of the written line returns old data.
  always_ff @(posedge clk) begin
    if (wrPop) begin
      mem_q[wrLine] <= wrData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeTag_q[i]   <= '0;
        pipeData_q[i]  <= '0;
      end
    end else begin
      pipeValid_q[0] <= rdPop;
      pipeTag_q[0]   <= rdPop ? rdTag : '0;
      pipeData_q[0]  <= rdPop ? rdMemData : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeTag_q[i]   <= pipeTag_q[i-1];
        pipeData_q[i]  <= pipeData_q[i-1];
      end
    end
  end

  // Final C0Rx register sits behind the READ_LATENCY pipeline stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c0RxValid_q <= 1'b0;
      c0RxHdr_q   <= '0;
      c0RxData_q  <= '0;
    end else begin
      c0RxValid_q <= pipeValid_q[READ_LATENCY-1];
      c0RxHdr_q   <= pipeValid_q[READ_LATENCY-1]
                     ? CCI_RX_HDR_WIDTH'(packRxHdr(RSP_RD, pipeTag_q[READ_LATENCY-1]))
                     : '0;
      c0RxData_q  <= pipeData_q[READ_LATENCY-1];
    end
  end

  // One pending C1 ack per cycle; interrupt takes the slot over a write pop.
  always_comb begin
    c1PendValid_d = bus.C1TxIrValid | wrPop;
    c1PendType_d  = RSP_WR;
    c1PendTag_d   = wrTag;
    if (bus.C1TxIrValid) begin
      c1PendType_d = RSP_IR;
      c1PendTag_d  = bus.C1TxHdr[CCI_TAG_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c1PendValid_q <= 1'b0;
      c1PendType_q  <= RSP_WR;
      c1PendTag_q   <= '0;
      c1RxWrValid_q <= 1'b0;
      c1RxIrValid_q <= 1'b0;
      c1RxHdr_q     <= '0;
    end else begin
      c1PendValid_q <= c1PendValid_d;
      c1PendType_q  <= c1PendType_d;
      c1PendTag_q   <= c1PendTag_d;
      c1RxWrValid_q <= c1PendValid_q && (c1PendType_q == RSP_WR);
      c1RxIrValid_q <= c1PendValid_q && (c1PendType_q == RSP_IR);
      c1RxHdr_q     <= c1PendValid_q
                       ? CCI_RX_HDR_WIDTH'(packRxHdr(c1PendType_q, c1PendTag_q))
                       : '0;
    end
  end

  assign overflow_d = overflow_q
                    | (bus.C0TxRdValid & rdFull)
                    | (bus.C1TxWrValid & wrFull);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // resetb asserts immediately with reset and releases on the 2nd clk edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign resetb   = rstSync_q[1];
  assign overflow = overflow_q;

  assign bus.C0TxAlmFull = (rdCount >= ALM_THRESH);
  assign bus.C1TxAlmFull = (wrCount >= ALM_THRESH);

  assign bus.C0RxHdr     = c0RxHdr_q;
  assign bus.C0RxData    = c0RxData_q;
  assign bus.C0RxRdValid = c0RxValid_q;
  assign bus.C0RxWrValid = 1'b0;
  assign bus.C0RxCgValid = 1'b0;
  assign bus.C0RxUgValid = 1'b0;
  assign bus.C0RxIrValid = 1'b0;

  assign bus.C1RxHdr     = c1RxHdr_q;
  assign bus.C1RxWrValid = c1RxWrValid_q;
  assign bus.C1RxIrValid = c1RxIrValid_q;

endmodule

// File: tb/tb_qa_qlp_mem_responder.sv
// Self-checking bench for qa_qlp_mem_responder. Expected responses are queued
// (with their due cycle) when requests are driven; monitors pop and compare
// whenever the DUT presents a C0Rx or C1Rx response.
module tb_qa_qlp_mem_responder;

  localparam int DW  = 512;
  localparam int TW  = 61;
  localparam int RW  = 18;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  logic resetb;
  logic overflow;

  qa_qlp_mem_responder_if #(
    .CCI_DATA_WIDTH   (DW),
    .CCI_RX_HDR_WIDTH (RW),
    .CCI_TX_HDR_WIDTH (TW)
  ) bus ();

  qa_qlp_mem_responder #(
    .CCI_DATA_WIDTH   (DW),
    .CCI_RX_HDR_WIDTH (RW),
    .CCI_TX_HDR_WIDTH (TW),
    .CCI_TAG_WIDTH    (14),
    .MEM_LINES_LG2    (6),
    .FIFO_DEPTH_LG2   (4),
    .ALM_FULL_SLACK   (8),
    .READ_LATENCY     (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .resetb   (resetb),
    .overflow (overflow),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0]   tag;
    logic [DW-1:0] data;
    int            due;
  } c0_exp_t;

  typedef struct {
    logic [3:0]  typ;
    logic [13:0] tag;
    int          due;
  } c1_exp_t;

  c0_exp_t c0Exp[$];
  c1_exp_t c1Exp[$];
  c0_exp_t e0;
  c1_exp_t e1;

  logic [DW-1:0] model [64];

  // C0Rx monitor
  always begin
    @(posedge clk);
    #1;
    if (bus.C0RxRdValid === 1'b1) begin
      vecCount++;
      if (c0Exp.size() == 0) begin
        missCount++;
        $display("[TB] FAIL c0_unexpected: got hdr %h at cycle %0d, required no response",
                 bus.C0RxHdr, cyc);
      end else begin
        e0 = c0Exp.pop_front();
        if (bus.C0RxHdr !== {4'h4, e0.tag} || bus.C0RxData !== e0.data || cyc != e0.due) begin
          missCount++;
          $display("[TB] FAIL c0_resp: got hdr %h cyc %0d data %h, required hdr %h cyc %0d data %h",
                   bus.C0RxHdr, cyc, bus.C0RxData, {4'h4, e0.tag}, e0.due, e0.data);
        end
      end
    end
  end

  // C1Rx monitor
  always begin
    @(posedge clk);
    #1;
    if (bus.C1RxWrValid === 1'b1 || bus.C1RxIrValid === 1'b1) begin
      vecCount++;
      if (c1Exp.size() == 0) begin
        missCount++;
        $display("[TB] FAIL c1_unexpected: got hdr %h at cycle %0d, required no response",
                 bus.C1RxHdr, cyc);
      end else begin
        e1 = c1Exp.pop_front();
        if (bus.C1RxHdr !== {e1.typ, e1.tag} || cyc != e1.due ||
            bus.C1RxWrValid !== (e1.typ == 4'h1) || bus.C1RxIrValid !== (e1.typ == 4'h8)) begin
          missCount++;
          $display("[TB] FAIL c1_resp: got hdr %h wr %b ir %b cyc %0d, required hdr %h cyc %0d",
                   bus.C1RxHdr, bus.C1RxWrValid, bus.C1RxIrValid, cyc, {e1.typ, e1.tag}, e1.due);
        end
      end
    end
  end

  task automatic drive(input logic rv, input logic [13:0] rtag, input logic [5:0] rline,
                       input logic wv, input logic iv, input logic [13:0] ctag,
                       input logic [5:0] cline, input logic [DW-1:0] d);
    logic [63:0]   junk;
    logic [TW-1:0] h0;
    logic [TW-1:0] h1;
    @(negedge clk);
    junk = {$urandom, $urandom};
    h0 = '0;
    h0[13:0]  = rtag;
    h0[19:14] = rline;
    h0[60:20] = junk[40:0];
    h1 = '0;
    h1[13:0]  = ctag;
    h1[19:14] = cline;
    h1[60:20] = junk[63:23];
    bus.C0TxRdValid = rv;
    bus.C0TxHdr     = h0;
    bus.C1TxWrValid = wv;
    bus.C1TxIrValid = iv;
    bus.C1TxHdr     = h1;
    bus.C1TxData    = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [DW-1:0] randLine();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecCount++;
    if (resetb !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL rst_resetb: got %b, required 0", resetb);
    end
    vecCount++;
    if ({bus.C0RxRdValid, bus.C0RxWrValid, bus.C0RxCgValid, bus.C0RxUgValid, bus.C0RxIrValid,
         bus.C1RxWrValid, bus.C1RxIrValid, bus.C0TxAlmFull, bus.C1TxAlmFull, overflow} !== 10'b0) begin
      missCount++;
      $display("[TB] FAIL rst_flags: got %b, required 0",
               {bus.C0RxRdValid, bus.C0RxWrValid, bus.C0RxCgValid, bus.C0RxUgValid,
                bus.C0RxIrValid, bus.C1RxWrValid, bus.C1RxIrValid, bus.C0TxAlmFull,
                bus.C1TxAlmFull, overflow});
    end
    vecCount++;
    if (bus.C0RxHdr !== '0 || bus.C1RxHdr !== '0 || bus.C0RxData !== '0) begin
      missCount++;
      $display("[TB] FAIL rst_hdr_data: got c0hdr %h c1hdr %h data_or %b, required 0",
               bus.C0RxHdr, bus.C1RxHdr, |bus.C0RxData);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    vecCount++;
    if (resetb !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL resetb_edge1: got %b, required 0", resetb);
    end
    @(posedge clk);
    #1;
    vecCount++;
    if (resetb !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL resetb_edge2: got %b, required 1", resetb);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    int t;
    d = {16{32'hA5A5A5A5}};
    drive(1'b0, '0, '0, 1'b1, 1'b0, 14'h12, 6'd3, d);
    t = cyc + 1;
    model[3] = d;
    c1Exp.push_back('{typ: 4'h1, tag: 14'h12, due: t + 2});
    drive(1'b1, 14'h34, 6'd3, 1'b0, 1'b0, '0, '0, '0);
    t = cyc + 1;
    c0Exp.push_back('{tag: 14'h34, data: model[3], due: t + 1 + LAT});
    idle(10);
  endtask

  task automatic test_same_line();
    logic [DW-1:0] one;
    logic [DW-1:0] nv;
    int t;
    one = '0;
    one[0] = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0, 14'h40, 6'd5, one);
    t = cyc + 1;
    model[5] = one;
    c1Exp.push_back('{typ: 4'h1, tag: 14'h40, due: t + 2});
    idle(4);
    nv = randLine();
    drive(1'b1, 14'h41, 6'd5, 1'b1, 1'b0, 14'h42, 6'd5, nv);
    t = cyc + 1;
    c1Exp.push_back('{typ: 4'h1, tag: 14'h42, due: t + 2});
    c0Exp.push_back('{tag: 14'h41, data: model[5], due: t + 1 + LAT});
    model[5] = nv;
    drive(1'b1, 14'h43, 6'd5, 1'b0, 1'b0, '0, '0, '0);
    t = cyc + 1;
    c0Exp.push_back('{tag: 14'h43, data: model[5], due: t + 1 + LAT});
    idle(10);
  endtask

  task automatic test_back_to_back();
    int t;
    logic [5:0] ln;
    for (int i = 0; i < 8; i++) begin
      ln = (i % 2 == 0) ? 6'd3 : 6'd5;
      drive(1'b1, 14'(16'h200 + i), ln, 1'b0, 1'b0, '0, '0, '0);
      t = cyc + 1;
      c0Exp.push_back('{tag: 14'(16'h200 + i), data: model[ln], due: t + 1 + LAT});
    end
    idle(12);
  endtask

  task automatic test_ir_conflict();
    logic [DW-1:0] d;
    int tw;
    d = randLine();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 14'h50, 6'd7, d);
    tw = cyc + 1;
    model[7] = d;
    drive(1'b0, '0, '0, 1'b0, 1'b1, 14'h7, 6'd0, '0);
    c1Exp.push_back('{typ: 4'h8, tag: 14'h7, due: tw + 2});
    c1Exp.push_back('{typ: 4'h1, tag: 14'h50, due: tw + 3});
    drive(1'b1, 14'h51, 6'd7, 1'b0, 1'b0, '0, '0, '0);
    c0Exp.push_back('{tag: 14'h51, data: model[7], due: cyc + 2 + LAT});
    idle(10);
  endtask

  // Holding C1TxIrValid suppresses write pops, so the write FIFO fills up.
  task automatic test_fill_overflow();
    int t0;
    int ti;
    int occ;
    logic expAlm;
    logic [DW-1:0] d;
    t0 = 0;
    for (int i = 0; i < 17; i++) begin
      d = randLine();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 14'(16'h100 + i), 6'(16 + (i % 16)), d);
      ti = cyc + 1;
      if (i == 0) t0 = ti;
      if (i < 16) model[16 + i] = d;
      c1Exp.push_back('{typ: 4'h8, tag: 14'(16'h100 + i), due: ti + 1});
      @(posedge clk);
      #1;
      occ = (i + 1 > 16) ? 16 : i + 1;
      expAlm = (occ >= 8);
      vecCount++;
      if (bus.C1TxAlmFull !== expAlm || overflow !== (i == 16)) begin
        missCount++;
        $display("[TB] FAIL fill_%0d: got almfull %b overflow %b, required almfull %b overflow %b",
                 i, bus.C1TxAlmFull, overflow, expAlm, (i == 16));
      end
    end
    vecCount++;
    if (bus.C0TxAlmFull !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL c0_almfull_idle: got %b, required 0", bus.C0TxAlmFull);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    for (int j = 0; j < 16; j++) begin
      c1Exp.push_back('{typ: 4'h1, tag: 14'(16'h100 + j), due: t0 + 18 + j});
    end
    repeat (30) @(posedge clk);
    #1;
    vecCount++;
    if (bus.C1TxAlmFull !== 1'b0 || overflow !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL drained: got almfull %b overflow %b, required almfull 0 overflow 1",
               bus.C1TxAlmFull, overflow);
    end
  endtask

  task automatic test_reset_flush();
    int t;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 14'(16'h300 + i), 6'd3, 1'b0, 1'b0, '0, '0, '0);
    end
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vecCount++;
    if (overflow !== 1'b0 || resetb !== 1'b0 || bus.C0RxRdValid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL flush_in_reset: got overflow %b resetb %b rdvalid %b, required 0 0 0",
               overflow, resetb, bus.C0RxRdValid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    vecCount++;
    if (resetb !== 1'b1 || overflow !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL flush_after: got resetb %b overflow %b, required 1 0", resetb, overflow);
    end
    drive(1'b1, 14'h3FF, 6'd3, 1'b0, 1'b0, '0, '0, '0);
    t = cyc + 1;
    c0Exp.push_back('{tag: 14'h3FF, data: model[3], due: t + 1 + LAT});
    idle(10);
  endtask

  initial begin
    reset = 1'b1;
    bus.C0TxRdValid = 1'b0;
    bus.C0TxHdr     = '0;
    bus.C1TxWrValid = 1'b0;
    bus.C1TxIrValid = 1'b0;
    bus.C1TxHdr     = '0;
    bus.C1TxData    = '0;

    test_reset();
    test_write_read();
    test_same_line();
    test_back_to_back();
    test_ir_conflict();
    test_fill_overflow();
    test_reset_flush();

    vecCount++;
    if (c0Exp.size() != 0 || c1Exp.size() != 0) begin
      missCount++;
      $display("[TB] FAIL missing_responses: got %0d c0 and %0d c1 outstanding, required 0 and 0",
               c0Exp.size(), c1Exp.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
